// File: rtl/uart_receiver.sv
// UART receiver: synchronized rx line, mid-bit sampling of 8N1 frames, and a
// byte/frame-error handshake held until the downstream controller acknowledges.
module uart_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] clk_div,
    input  logic        rx,
    input  logic        ctrl_byte_finish,
    output logic [7:0]  rx_data,
    output logic        byte_finish,
    output logic        rx_busy,
    output logic        frame_err
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_ACK
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_d;
    logic [31:0]            bit_period;
    logic [31:0]            cnt;
    logic [31:0]            target;
    logic                   sample;
    logic [2:0]             bit_idx;
    logic [7:0]             shift_q;

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Synchronizer and edge-detect flops idle high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '1;
            rx_d   <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every flop see the pre-edge value of its neighbour.
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            rx_d   <= rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        target    = bit_period;
        sample    = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_d && !rx_s) begin
                    state_nxt = START;
                end
            end
            START: begin
                target = bit_period >> 1;
                sample = (cnt == target - 32'd1);
                if (sample) begin
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                sample = (cnt == target - 32'd1);
                if (sample && bit_idx == 3'd7) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                sample = (cnt == target - 32'd1);
                if (sample) begin
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ctrl_byte_finish) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_period  <= 32'd2;
            cnt         <= '0;
            bit_idx     <= '0;
            shift_q     <= '0;
            rx_data     <= '0;
            byte_finish <= 1'b0;
            frame_err   <= 1'b0;
            rx_busy     <= 1'b0;
        end else begin
            rx_busy <= (state_nxt != IDLE);

            // Counter restarts on every state entry and after each sample point.
            if (state == IDLE || state_nxt != state || sample) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 32'd1;
            end

            // Bit period is frozen for the whole frame; anything below 2 would zero the half-bit target.
            if (state == IDLE && state_nxt == START) begin
                bit_period <= (clk_div < 32'd2) ? 32'd2 : clk_div;
            end

            if (state == START) begin
                bit_idx <= '0;
            end

            if (state == DATA && sample) begin
                shift_q <= {rx_s, shift_q[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end

            if (state == STOP && sample) begin
                if (rx_s) begin
                    rx_data     <= shift_q;
                    byte_finish <= 1'b1;
                end else begin
                    frame_err   <= 1'b1;
                end
            end

            if (state == WAIT_ACK && ctrl_byte_finish) begin
                byte_finish <= 1'b0;
                frame_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: a frame-level timing model checked against the DUT
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_uart_receiver;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] clk_div = 32'd8;
    logic        rx = 1'b1;
    logic        ack = 1'b0;
    logic [7:0]  rx_data;
    logic        byte_finish;
    logic        rx_busy;
    logic        frame_err;

    uart_receiver #(.SYNC_STAGES(SYNC)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .clk_div          (clk_div),
        .rx               (rx),
        .ctrl_byte_finish (ack),
        .rx_data          (rx_data),
        .byte_finish      (byte_finish),
        .rx_busy          (rx_busy),
        .frame_err        (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (time %0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a frame whose falling edge is driven just after edge c0
    // makes the receiver busy from edge c0+SYNC+1 and raises its flag half a bit
    // plus nine bits later; a glitch drops busy again after the half bit.
    int         cyc = 0;
    bit         cmp_en = 1'b0;
    logic [7:0] m_data = 8'h00;
    bit         m_bf = 1'b0;
    bit         m_fe = 1'b0;
    bit         m_busy = 1'b0;
    bit         ev_active = 1'b0;
    bit         ev_glitch = 1'b0;
    bit         ev_stop_ok = 1'b0;
    logic [7:0] ev_byte = 8'h00;
    int         ev_start = 0;
    int         ev_end = 0;
    int         frame_c0 = 0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        if (!rst_n) begin
            m_data    = 8'h00;
            m_bf      = 1'b0;
            m_fe      = 1'b0;
            m_busy    = 1'b0;
            ev_active = 1'b0;
            cmp_en    = 1'b1;
        end else begin
            if ((m_bf || m_fe) && ack) begin
                m_bf   = 1'b0;
                m_fe   = 1'b0;
                m_busy = 1'b0;
            end
            if (ev_active && cyc == ev_start) m_busy = 1'b1;
            if (ev_active && cyc == ev_end) begin
                if (ev_glitch) begin
                    m_busy = 1'b0;
                end else if (ev_stop_ok) begin
                    m_data = ev_byte;
                    m_bf   = 1'b1;
                end else begin
                    m_fe   = 1'b1;
                end
                ev_active = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("rx_data",     rx_data,     m_data);
            check("byte_finish", byte_finish, m_bf);
            check("frame_err",   frame_err,   m_fe);
            check("rx_busy",     rx_busy,     m_busy);
            check("flags_exclusive", byte_finish & frame_err, 0);
        end
    end

    function automatic int clamp_bp(input logic [31:0] d);
        return (d < 32'd2) ? 2 : int'(d);
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit hold_low);
        int         bp;
        logic [9:0] bits;
        @(posedge clk); #1;
        bp         = clamp_bp(clk_div);
        frame_c0   = cyc;
        ev_start   = cyc + SYNC + 1;
        ev_end     = ev_start + bp / 2 + 9 * bp;
        ev_glitch  = 1'b0;
        ev_stop_ok = stop_ok;
        ev_byte    = b;
        ev_active  = 1'b1;
        bits = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (bp) @(posedge clk);
            #1;
        end
        rx = hold_low ? 1'b0 : 1'b1;
    endtask

    task automatic send_glitch(input int n);
        int bp;
        @(posedge clk); #1;
        bp        = clamp_bp(clk_div);
        ev_start  = cyc + SYNC + 1;
        ev_end    = ev_start + bp / 2;
        ev_glitch = 1'b1;
        ev_active = 1'b1;
        rx = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rx = 1'b1;
    endtask

    task automatic wait_flag(input int limit, output int at_cyc, output bit ok);
        ok     = 1'b0;
        at_cyc = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (byte_finish || frame_err) begin
                at_cyc = cyc;
                ok     = 1'b1;
                return;
            end
        end
    endtask

    task automatic ack_pulse();
        @(posedge clk); #1;
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
    endtask

    int t;
    bit ok;
    int nb;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_busy", rx_busy, 0);
        check("reset_flags", {byte_finish, frame_err}, 0);

        // Nominal 0xA5 frame at 8 cycles per bit.
        clk_div = 32'd8;
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            wait_flag(2000, t, ok);
        join
        check("a5_flag_seen", ok, 1);
        check("a5_latency", t - (frame_c0 + SYNC), 77);
        check("a5_data", rx_data, 8'hA5);
        check("a5_busy_until_ack", rx_busy, 1);
        ack_pulse();
        @(negedge clk);
        check("a5_busy_after_ack", rx_busy, 0);

        // Same frame, a stray ack mid-frame, then acknowledge 20 cycles late.
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            wait_flag(2000, t, ok);
            begin
                repeat (30) @(posedge clk);
                #1 ack = 1'b1;
                @(posedge clk);
                #1 ack = 1'b0;
            end
        join
        check("late_flag_seen", ok, 1);
        repeat (20) @(posedge clk);
        #1;
        check("late_bf_held", byte_finish, 1);
        check("late_busy_held", rx_busy, 1);
        ack_pulse();
        @(negedge clk);
        check("late_bf_cleared", byte_finish, 0);
        check("late_busy_cleared", rx_busy, 0);

        // 0x3C with a bad stop bit, line held low afterwards.
        clk_div = 32'd16;
        fork
            send_frame(8'h3C, 1'b0, 1'b1);
            wait_flag(4000, t, ok);
        join
        check("ferr_flag_seen", ok, 1);
        check("ferr_latency", t - (frame_c0 + SYNC), 153);
        check("ferr_frame_err", frame_err, 1);
        check("ferr_no_byte", byte_finish, 0);
        check("ferr_data_kept", rx_data, 8'hA5);
        ack_pulse();
        repeat (40) @(negedge clk);
        check("ferr_low_line_no_start", rx_busy, 0);
        @(posedge clk);
        #1 rx = 1'b1;
        repeat (5) @(posedge clk);
        fork
            send_frame(8'h5A, 1'b1, 1'b0);
            wait_flag(4000, t, ok);
        join
        check("after_ferr_flag_seen", ok, 1);
        check("after_ferr_data", rx_data, 8'h5A);
        ack_pulse();

        // Two-cycle low glitch.
        clk_div = 32'd8;
        nb = 0;
        fork
            send_glitch(2);
            begin
                repeat (20) begin
                    @(negedge clk);
                    if (rx_busy) nb++;
                end
            end
        join
        check("glitch_busy_cycles", nb, 4);
        check("glitch_no_flags", {byte_finish, frame_err}, 0);

        // clk_div = 1 clamps to 2; a mid-frame change to 100 must not matter.
        clk_div = 32'd1;
        fork
            send_frame(8'h81, 1'b1, 1'b0);
            wait_flag(2000, t, ok);
            begin
                repeat (8) @(posedge clk);
                #1 clk_div = 32'd100;
            end
        join
        check("clamp_flag_seen", ok, 1);
        check("clamp_latency", t - (frame_c0 + SYNC), 20);
        check("clamp_data", rx_data, 8'h81);
        ack_pulse();

        // Reset during data bit 4 of 0xFF, then a clean 0x12 frame.
        clk_div = 32'd8;
        fork
            send_frame(8'hFF, 1'b1, 1'b0);
            begin
                repeat (44) @(posedge clk);
                #1 rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
                @(negedge clk);
                check("midreset_data", rx_data, 8'h00);
                check("midreset_busy", rx_busy, 0);
                check("midreset_flags", {byte_finish, frame_err}, 0);
            end
        join
        check("midreset_no_byte", byte_finish, 0);
        fork
            send_frame(8'h12, 1'b1, 1'b0);
            wait_flag(2000, t, ok);
        join
        check("post_reset_flag_seen", ok, 1);
        check("post_reset_latency", t - (frame_c0 + SYNC), 77);
        check("post_reset_data", rx_data, 8'h12);
        ack_pulse();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of flops on the rx input synchronizer (minimum 2).
REQ-002 Reset is synchronous and active-low; the block runs on a single clock.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 clk_div  input  32  clock cycles per UART bit period.
REQ-006 rx  input  1  asynchronous serial line; idle high.
REQ-007 ctrl_byte_finish  input  1  acknowledge from the downstream controller; clears the pending byte or error.
REQ-008 rx_data  output  8  last received byte.
REQ-009 byte_finish  output  1  a valid byte is pending in rx_data.
REQ-010 rx_busy  output  1  a frame is in progress or awaiting acknowledge.
REQ-011 frame_err  output  1  the pending frame had stop bit = 0.

Function
REQ-012 rx SHALL pass through SYNC_STAGES flops, reset to 1, giving rx_s; a further flop rx_d SHALL feed falling-edge detection.
REQ-013 The FSM states SHALL be IDLE, START, DATA, STOP and WAIT_ACK.
REQ-014 bit_period SHALL be latched from clk_div on leaving IDLE; if clk_div < 2 the latched value SHALL be 2; clk_div changes mid-frame SHALL have no effect.
REQ-015 IDLE -> START SHALL occur only when rx_d = 1 and rx_s = 0; a line held low never starts a frame.
REQ-016 A 32-bit counter SHALL reset to 0 on every state entry and after every sample; a sample SHALL occur when the counter equals target-1.
REQ-017 START target = bit_period>>1; if the rx_s sample = 0, go to DATA; if it = 1 (glitch), return to IDLE with no output pulse.
REQ-018 DATA target = bit_period; 8 samples, LSB first, are shifted into a shift register; after the 8th sample, go to STOP.
REQ-019 STOP target = bit_period.
  - Sample = 1: rx_data <= shift register; byte_finish <= 1.
  - Sample = 0: frame_err <= 1; rx_data is unchanged.
  - Either case: go to WAIT_ACK.
REQ-020 byte_finish and frame_err SHALL assert on the clock after the stop sample and hold until ctrl_byte_finish = 1 is seen in WAIT_ACK.
REQ-021 On that acknowledge, both flags SHALL clear on the next edge and the FSM SHALL go to IDLE.
REQ-022 ctrl_byte_finish in any state other than WAIT_ACK SHALL be ignored.
REQ-023 rx_busy SHALL be 1 in START, DATA, STOP and WAIT_ACK, and 0 in IDLE (registered, same edge as the state change).
REQ-024 A falling edge on rx during WAIT_ACK SHALL be ignored; the next frame is detected only from IDLE.
REQ-025 byte_finish and frame_err SHALL never be 1 simultaneously.
REQ-026 End-to-end latency, first rx_s = 0 cycle to byte_finish = 1, SHALL be (bit_period>>1) + 9*bit_period + 1 cycles.

Reset
REQ-027 rst_n = 0 at any clock edge SHALL force IDLE, rx_data = 0, byte_finish = 0, frame_err = 0, rx_busy = 0, counter = 0, shift register = 0, and all synchronizer flops and rx_d = 1.
REQ-028 Reset mid-frame SHALL discard the partial byte; after release, reception SHALL resume only at a new falling edge.

Verification
REQ-029 clk_div = 8, send 0xA5 with a valid stop bit -> byte_finish = 1 exactly 77 cycles after first rx_s = 0, rx_data = 0xA5, rx_busy = 1 until acknowledged.
REQ-030 Same frame with ack delayed 20 cycles -> byte_finish and rx_busy held 20 cycles, then clear on the edge after ack, state = IDLE.
REQ-031 clk_div = 16, send 0x3C with stop bit = 0 -> frame_err = 1, byte_finish = 0, rx_data retains the previous value; rx held low afterwards -> no new frame until rx returns high and falls again.
REQ-032 2-cycle low glitch on rx, clk_div = 8 -> return to IDLE, no byte_finish, no frame_err, rx_busy high for at most 5 cycles.
REQ-033 clk_div = 1 (clamped to 2), send 0x81 -> rx_data = 0x81 after 1 + 18 + 1 = 20 cycles; clk_div changed to 100 mid-frame -> timing unchanged.
REQ-034 rst_n low during the DATA bit 4 of 0xFF -> all outputs = 0 the next cycle; a following 0x12 frame is received correctly.
